// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that processes DIGIT bits per clock.
//
// Two WIDTH-bit operands and a carry-in are captured on an accepted start
// pulse. The adder then resolves them digit by digit, least significant digit
// first, keeping a single carry flop between digits. After N = WIDTH/DIGIT
// RUN cycles the sum, carry-out and signed overflow registers update and
// done pulses for one cycle.
//
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input. When sub=1 the
// unit computes a - b - cin (cin is a borrow-in, cout is NOT borrow-out).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears control and datapath)
//   start     request, honoured only in IDLE or DONE
//   a, b      operands, captured when start is accepted
//   cin       carry-in (borrow-in when subtracting), captured with operands
//   sub       (SERIAL_ADDER_SUB_EN only) 1 = subtract, captured with operands
//   busy      high while digits are being processed
//   done      one-cycle pulse when sum/cout/overflow update
//   sum       registered result, modulo 2^WIDTH
//   cout      registered carry out of bit WIDTH-1
//   overflow  registered signed overflow
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_adder: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic               sub_op;
  logic               accept;
  logic               last;
  logic [DIGIT:0]     d_res;
  logic [WIDTH-1:0]   sum_next;
  logic               msb_cin;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_op = sub;
`else
  assign sub_op = 1'b0;
`endif

  // One digit of addition: DIGIT-bit operands plus carry, DIGIT+1-bit result.
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
  endfunction

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CNT_W'(N - 1));
  assign d_res  = digit_add(a_sh[DIGIT-1:0], b_sh[DIGIT-1:0], carry);

  // New digit enters at the top; after N shifts the register holds the full
  // sum with the first digit at the bottom.
  assign sum_next = (sum_sh >> DIGIT) |
                    (WIDTH'(d_res[DIGIT-1:0]) << (WIDTH - DIGIT));

  // On the last digit, bit DIGIT-1 of the digit is the operand MSB, so the
  // carry into it is recovered as a ^ b ^ sum at that bit position.
  assign msb_cin = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ d_res[DIGIT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is folded in at capture time: a - b - borrow equals
  // a + ~b + ~borrow, so the serial datapath itself only ever adds.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= sub_op ? ~b : b;
      carry  <= sub_op ? ~cin : cin;
      sum_sh <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      sum_sh <= sum_next;
      carry  <= d_res[DIGIT];
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        sum      <= sum_next;
        cout     <= d_res[DIGIT];
        overflow <= msb_cin ^ d_res[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: two instances (DIGIT=1 and DIGIT=4, WIDTH=8)
// share clock and reset. A transaction-level model predicts busy/done timing
// and results from plain arithmetic; a compare process checks every cycle,
// and directed tests pin the model with hand-computed literals.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       st   [2];
  logic [7:0] ai   [2];
  logic [7:0] bi   [2];
  logic       ci   [2];
  logic       sbi  [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic [7:0] sum_o  [2];
  logic       cout_o [2];
  logic       ovf_o  [2];

  int vectors;
  int miscompares;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk      (clk),
    .rst      (rst),
    .start    (st[0]),
    .a        (ai[0]),
    .b        (bi[0]),
    .cin      (ci[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sbi[0]),
`endif
    .busy     (busy_o[0]),
    .done     (done_o[0]),
    .sum      (sum_o[0]),
    .cout     (cout_o[0]),
    .overflow (ovf_o[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk      (clk),
    .rst      (rst),
    .start    (st[1]),
    .a        (ai[1]),
    .b        (bi[1]),
    .cin      (ci[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sbi[1]),
`endif
    .busy     (busy_o[1]),
    .done     (done_o[1]),
    .sum      (sum_o[1]),
    .cout     (cout_o[1]),
    .overflow (ovf_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", nm, k, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  // left = busy cycles still to come; result committed when it reaches 0.
  int         left  [2] = '{0, 0};
  logic       mdone [2] = '{1'b0, 1'b0};
  logic [7:0] msum  [2] = '{8'h00, 8'h00};
  logic       mcout [2] = '{1'b0, 1'b0};
  logic       movf  [2] = '{1'b0, 1'b0};
  logic [7:0] psum  [2];
  logic       pcout [2];
  logic       povf  [2];
  logic [8:0] full;
  logic [7:0] bx;
  logic       cx;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        left[k] = 0; mdone[k] = 1'b0;
        msum[k] = 8'h00; mcout[k] = 1'b0; movf[k] = 1'b0;
      end else if (left[k] > 0) begin
        left[k]  = left[k] - 1;
        mdone[k] = (left[k] == 0);
        if (left[k] == 0) begin
          msum[k] = psum[k]; mcout[k] = pcout[k]; movf[k] = povf[k];
        end
      end else begin
        mdone[k] = 1'b0;
        if (st[k]) begin
          left[k] = (k == 0) ? 8 : 2;
          bx   = sbi[k] ? ~bi[k] : bi[k];
          cx   = sbi[k] ? ~ci[k] : ci[k];
          full = {1'b0, ai[k]} + {1'b0, bx} + {8'h00, cx};
          psum[k]  = full[7:0];
          pcout[k] = full[8];
          povf[k]  = (ai[k][7] == bx[7]) && (full[7] != ai[k][7]);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      check("busy", k, 32'(busy_o[k]), 32'(left[k] > 0));
      check("done", k, 32'(done_o[k]), 32'(mdone[k]));
      check("sum",  k, 32'(sum_o[k]),  32'(msum[k]));
      check("cout", k, 32'(cout_o[k]), 32'(mcout[k]));
      check("ovf",  k, 32'(ovf_o[k]),  32'(movf[k]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present operands with start for one edge, then scramble the inputs so a
  // late operand change would be visible in the result.
  task automatic go(input int k, input logic [7:0] x, input logic [7:0] y,
                    input logic c, input logic s);
    st[k] = 1'b1; ai[k] = x; bi[k] = y; ci[k] = c; sbi[k] = s;
    tick();
    st[k] = 1'b0; ai[k] = ~x; bi[k] = ~y; ci[k] = ~c;
  endtask

  // Wait (bounded) for done; returns number of busy cycles observed first.
  task automatic wait_done(input int k, output int nbusy);
    int i;
    nbusy = 0;
    i = 0;
    while (done_o[k] !== 1'b1 && i < 30) begin
      if (busy_o[k] === 1'b1) nbusy++;
      tick();
      i++;
    end
    check("done_seen", k, 32'(done_o[k]), 32'd1);
  endtask

  task automatic expect_res(input string nm, input int k, input logic [7:0] s,
                            input logic c, input logic o);
    check({nm, "_sum"},  k, 32'(sum_o[k]),  32'(s));
    check({nm, "_cout"}, k, 32'(cout_o[k]), 32'(c));
    check({nm, "_ovf"},  k, 32'(ovf_o[k]),  32'(o));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int ndone;
    int first_t;
    int last_t;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b1; ai[k] = 8'hA5; bi[k] = 8'h5A; ci[k] = 1'b1; sbi[k] = 1'b0;
    end

    // Test 1: reset held with start high
    tick();
    tick();
    check("rst_busy", 0, 32'(busy_o[0]), 32'd0);
    check("rst_done", 0, 32'(done_o[0]), 32'd0);
    expect_res("rst", 0, 8'h00, 1'b0, 1'b0);
    st[0] = 1'b0; st[1] = 1'b0;
    rst = 1'b0;
    tick();

    // Test 2: 0xFF + 0x01
    go(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(0, nb);
    check("t2_busy_cycles", 0, 32'(nb), 32'd8);
    expect_res("t2", 0, 8'h00, 1'b1, 1'b0);
    tick();
    check("t2_done_pulse", 0, 32'(done_o[0]), 32'd0);

    // Test 3: signed overflow cases
    go(0, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done(0, nb);
    expect_res("t3a", 0, 8'h80, 1'b0, 1'b1);
    go(0, 8'h80, 8'h80, 1'b1, 1'b0);
    wait_done(0, nb);
    expect_res("t3b", 0, 8'h01, 1'b1, 1'b1);

    // Test 4: DIGIT=4 instance, then start held for back-to-back operation
    go(1, 8'h3C, 8'h4B, 1'b1, 1'b0);
    wait_done(1, nb);
    check("t4_busy_cycles", 1, 32'(nb), 32'd2);
    expect_res("t4", 1, 8'h88, 1'b0, 1'b1);
    st[1] = 1'b1; ai[1] = 8'h10; bi[1] = 8'h20; ci[1] = 1'b0;
    ndone = 0; first_t = -1; last_t = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_o[1] === 1'b1) begin
        ndone++;
        if (first_t < 0) first_t = i;
        last_t = i;
      end
    end
    check("t4_b2b_count", 1, 32'(ndone), 32'd4);
    check("t4_b2b_span", 1, 32'(last_t - first_t), 32'd9);
    check("t4_b2b_sum", 1, 32'(sum_o[1]), 32'h30);
    st[1] = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Test 5a: start during busy is ignored
    go(0, 8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    st[0] = 1'b1; ai[0] = 8'hFF; bi[0] = 8'hFF; ci[0] = 1'b0;
    tick();
    st[0] = 1'b0;
    wait_done(0, nb);
    expect_res("t5a", 0, 8'h46, 1'b0, 1'b0);
    tick();

    // Test 5b: reset on the 4th busy cycle discards the operation
    go(0, 8'h55, 8'h22, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check("t5b_busy4", 0, 32'(busy_o[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o[0] === 1'b1) ndone++;
      tick();
    end
    check("t5b_no_done", 0, 32'(ndone), 32'd0);
    expect_res("t5b", 0, 8'h00, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    // Test 6: subtraction
    go(0, 8'h05, 8'h07, 1'b0, 1'b1);
    wait_done(0, nb);
    expect_res("t6a", 0, 8'hFE, 1'b0, 1'b0);
    go(0, 8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(0, nb);
    expect_res("t6b", 0, 8'h7F, 1'b1, 1'b1);
    sbi[0] = 1'b0;
`endif

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
